// File: rtl/uart_tx_fifo.sv
// Byte FIFO and sequencer feeding a UART transmitter, keeping tx_trigger high across queued bytes.
// Optional sticky overflow flag enabled by defining UART_TX_FIFO_OVF_EN.
module uart_tx_fifo #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic [7:0]        tx_byte,
  output logic              tx_trigger,
  input  logic              tx_done,
  output logic              busy,
  output logic              overflow
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state_q, state_d;
  logic [7:0]          mem_q [DEPTH];
  logic [ADDR_W-1:0]   wptr_q, wptr_d;
  logic [ADDR_W-1:0]   rptr_q, rptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                full_q, full_d;
  logic                empty_q, empty_d;
  logic [7:0]          tx_byte_q, tx_byte_d;
  logic                wr_ok;
  logic                pop;

  always_comb begin
    wr_ok   = wr_en && !full_q;
    pop     = 1'b0;
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!empty_q) begin
          pop     = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        // tx_done with nothing queued ends the stream; a same-cycle write waits for IDLE
        if (tx_done) begin
          if (!empty_q) pop = 1'b1;
          else          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    wptr_d    = wr_ok ? wptr_q + ADDR_W'(1) : wptr_q;
    rptr_d    = pop   ? rptr_q + ADDR_W'(1) : rptr_q;
    tx_byte_d = pop   ? mem_q[rptr_q] : tx_byte_q;

    case ({wr_ok, pop})
      2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
      default: count_d = count_q;
    endcase

    full_d  = (count_d == FULL_CNT);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      tx_byte_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      tx_byte_q <= tx_byte_d;
    end
  end

  // Storage is not reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wptr_q] <= wr_data;
  end

`ifdef UART_TX_FIFO_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q || (wr_en && full_q);
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

  assign full       = full_q;
  assign empty      = empty_q;
  assign count      = count_q;
  assign tx_byte    = tx_byte_q;
  assign tx_trigger = (state_q == SEND);
  assign busy       = (state_q == SEND) || (count_q != '0);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo with a simple transmitter model answering tx_trigger with tx_done.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       tx_done = 1'b0;
  logic       full, empty, tx_trigger, busy, overflow;
  logic [4:0] count;
  logic [7:0] tx_byte;

  uart_tx_fifo #(.ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .tx_byte(tx_byte),
    .tx_trigger(tx_trigger), .tx_done(tx_done), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  logic [7:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transmitter model: manual tx_done requests, or an automatic 10-cycle frame while triggered.
  int   done_req = 0;
  int   done_ack = 0;
  int   frame_cnt = 0;
  logic tx_auto = 1'b0;

  always @(posedge clk) begin
    #2;
    tx_done = 1'b0;
    if (done_req != done_ack) begin
      tx_done = 1'b1;
      done_ack++;
    end else if (tx_auto && tx_trigger) begin
      if (frame_cnt == 9) begin
        tx_done   = 1'b1;
        frame_cnt = 0;
      end else begin
        frame_cnt++;
      end
    end else begin
      frame_cnt = 0;
    end
  end

  // Monitor: a new byte starts on trigger rise or the cycle after tx_done while still triggered.
  logic trig_prev = 1'b0;
  logic done_prev = 1'b0;
  int   fall_cnt  = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (tx_trigger && (!trig_prev || done_prev)) begin
        if (exp_q.size() == 0) chk("pop_underflow", 0, 1);
        else                   chk("tx_byte_order", tx_byte, exp_q.pop_front());
      end
      if (trig_prev && !tx_trigger) begin
        fall_cnt++;
        chk("gapless_fall", exp_q.size(), 0);
      end
    end
    trig_prev = tx_trigger;
    done_prev = tx_done;
  end

  task automatic wait_idle(input int max);
    int n = 0;
    while ((tx_trigger || !empty) && n < max) begin
      step();
      n++;
    end
    chk("idle_timeout", n < max, 1);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int f0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_trigger", tx_trigger, 0);
    chk("rst_byte", tx_byte, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    step();

    // Single byte latency
    wr_en = 1'b1; wr_data = 8'hA5; exp_q.push_back(8'hA5);
    step();
    wr_en = 1'b0;
    @(negedge clk);
    chk("a5_empty_n", empty, 0);
    chk("a5_count_n", count, 1);
    chk("a5_trig_n", tx_trigger, 0);
    step();
    @(negedge clk);
    chk("a5_trig_n1", tx_trigger, 1);
    chk("a5_byte_n1", tx_byte, 8'hA5);
    chk("a5_count_n1", count, 0);
    chk("a5_busy_n1", busy, 1);
    step();
    done_req++;
    step();
    @(negedge clk);
    chk("a5_trig_done", tx_trigger, 0);
    chk("a5_busy_done", busy, 0);
    step();

    // Back-to-back stream
    f0 = fall_cnt;
    tx_auto = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      wr_en = 1'b1; wr_data = 8'(i); exp_q.push_back(8'(i));
      step();
    end
    wr_en = 1'b0;
    wait_idle(200);
    chk("stream_falls", fall_cnt - f0, 1);
    chk("stream_busy", busy, 0);
    tx_auto = 1'b0;

    // Fill while SEND is stalled, then one extra write
    wr_en = 1'b1; wr_data = 8'hEE; exp_q.push_back(8'hEE);
    step();
    wr_en = 1'b0;
    step();
    for (int i = 0; i <= 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      if (i < 16) exp_q.push_back(8'(i));
      step();
    end
    wr_en = 1'b0;
    @(negedge clk);
    chk("full_count", count, 16);
    chk("full_flag", full, 1);
    chk("full_empty", empty, 0);
    chk("full_busy", busy, 1);
    chk("full_held_byte", tx_byte, 8'hEE);
`ifdef UART_TX_FIFO_OVF_EN
    chk("full_overflow", overflow, 1);
`else
    chk("full_overflow", overflow, 0);
`endif
    step();

    // Drain to three entries, crossing the pointer wrap
    for (int i = 0; i < 13; i++) begin
      done_req++;
      step();
      step();
    end
    @(negedge clk);
    chk("drain_count", count, 3);
    chk("drain_byte", tx_byte, 8'h0C);
    step();

    // Write and pop in the same cycle
    wr_en = 1'b1; wr_data = 8'h55; exp_q.push_back(8'h55);
    done_req++;
    step();
    wr_en = 1'b0;
    @(negedge clk);
    chk("simul_count", count, 3);
    chk("simul_full", full, 0);
    chk("simul_byte", tx_byte, 8'h0D);
    step();
    tx_auto = 1'b1;
    wait_idle(300);
    tx_auto = 1'b0;
    chk("simul_drained_busy", busy, 0);

    // Reset mid-frame
    wr_en = 1'b1; wr_data = 8'h77; exp_q.push_back(8'h77);
    step();
    wr_data = 8'h78; exp_q.push_back(8'h78);
    step();
    wr_en = 1'b0;
    step();
    chk("pre_rst_trig", tx_trigger, 1);
    rst = 1'b1;
    exp_q.delete();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_trig", tx_trigger, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_byte", tx_byte, 8'h00);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_busy", busy, 0);
    step();
    done_req++;
    step();
    step();
    @(negedge clk);
    chk("post_rst_done_trig", tx_trigger, 0);
    chk("post_rst_done_busy", busy, 0);
    chk("post_rst_done_count", count, 0);
    step();

    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
